// File: rtl/sr_cond_pkg.sv
// Shared types and default timing for the SR latch input conditioner.
package sr_cond_pkg;

  localparam int unsigned DefDebounceCycles = 16;
  localparam int unsigned DefPulseCycles    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetPulse,
    StRstPulse,
    StGuard
  } sr_state_e;

endpackage

// File: rtl/sr_debounce.sv
// Synchronizes and debounces one raw button; flags each debounced press for one cycle.
module sr_debounce #(
  parameter int unsigned DebounceCycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic req_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The level flips on the mismatching cycle seen while the count already equals
  // DebounceCycles; any matching sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DebounceCycles)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign req_o = level_q & ~level_prev_q;

endmodule

// File: rtl/sr_input_conditioner.sv
// Turns two bouncy buttons into clean, mutually exclusive, fixed-width S/R pulses.
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned PULSE_CYCLES    = DefPulseCycles
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_SET,
  input  logic BTN_RST,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic CONFLICT,
  output logic DROP
);

  localparam int unsigned PcntW = $clog2(PULSE_CYCLES + 1);

  logic             set_req, rst_req;
  sr_state_e        state_q, state_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic             conflict_d, drop_d;

  sr_debounce #(
    .DebounceCycles(DEBOUNCE_CYCLES)
  ) u_deb_set (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .btn_i (BTN_SET),
    .req_o (set_req)
  );

  sr_debounce #(
    .DebounceCycles(DEBOUNCE_CYCLES)
  ) u_deb_rst (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .btn_i (BTN_RST),
    .req_o (rst_req)
  );

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    conflict_d = 1'b0;
    drop_d     = 1'b0;
    case (state_q)
      StIdle: begin
        pcnt_d = '0;
        if (set_req && rst_req) begin
          conflict_d = 1'b1;
        end else if (set_req) begin
          state_d = StSetPulse;
        end else if (rst_req) begin
          state_d = StRstPulse;
        end
      end
      StSetPulse, StRstPulse: begin
        if (pcnt_q == PcntW'(PULSE_CYCLES - 1)) begin
          state_d = StGuard;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PcntW'(1);
        end
      end
      StGuard: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Coincident requests while busy collapse into a single drop.
    if ((state_q != StIdle) && (set_req || rst_req)) begin
      drop_d = 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      pcnt_q   <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      BUSY     <= 1'b0;
      CONFLICT <= 1'b0;
      DROP     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      S        <= (state_d == StSetPulse);
      R        <= (state_d == StRstPulse);
      BUSY     <= (state_d != StIdle);
      CONFLICT <= conflict_d;
      DROP     <= drop_d;
    end
  end

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Scoreboard bench: a timing-level reference model queues expected outputs per cycle.
module tb_sr_input_conditioner;

  localparam int Deb = 16;
  localparam int Pw  = 4;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic s, r, busy, conflict, drop;

  sr_input_conditioner #(
    .DEBOUNCE_CYCLES(Deb),
    .PULSE_CYCLES   (Pw)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .BTN_SET (btn_set),
    .BTN_RST (btn_rst),
    .S       (s),
    .R       (r),
    .BUSY    (busy),
    .CONFLICT(conflict),
    .DROP    (drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {S,R,BUSY,CONFLICT,DROP} for each sample point.
  logic [4:0] exp_q[$];

  // Reference model: raw input history, debounced levels, and start edge of the pulse.
  logic [Deb+2:0] hist[2];
  logic [1:0]     m_lvl, m_lvl_prev;
  int             m_edge, m_start;
  logic           m_kind_set, m_conf, m_drop;

  // Monitor bookkeeping.
  int s_len = 0, r_len = 0;
  int s_count = 0, r_count = 0, conflict_count = 0, drop_count = 0;
  int s_rise_cyc = -1, last_busy_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    hist[0]    = '0;
    hist[1]    = '0;
    m_lvl      = '0;
    m_lvl_prev = '0;
    m_edge     = 0;
    m_start    = -100;
    m_kind_set = 1'b0;
    m_conf     = 1'b0;
    m_drop     = 1'b0;
  endtask

  // One active clock edge with the given raw inputs present at that edge.
  task automatic model_edge(input logic bs, input logic br);
    logic [1:0] req, in_b;
    logic [Deb:0] win;
    bit busy_before;
    m_edge++;
    req = m_lvl & ~m_lvl_prev;
    busy_before = ((m_edge - 1 - m_start) >= 0) && ((m_edge - 1 - m_start) <= Pw);
    m_conf = 1'b0;
    m_drop = 1'b0;
    if (req != 2'b00) begin
      if (busy_before) m_drop = 1'b1;
      else if (req == 2'b11) m_conf = 1'b1;
      else begin
        m_start    = m_edge;
        m_kind_set = req[0];
      end
    end
    m_lvl_prev = m_lvl;
    in_b = {br, bs};
    for (int b = 0; b < 2; b++) begin
      hist[b] = {hist[b][Deb+1:0], in_b[b]};
      // Samples seen by the debouncer lag the raw input by two edges.
      win = hist[b][Deb+2:2];
      if (m_lvl[b] ? (win == '0) : (&win)) m_lvl[b] = ~m_lvl[b];
    end
  endtask

  function automatic logic [4:0] model_out();
    int d;
    logic ps, pr, pb;
    d  = m_edge - m_start;
    ps = (d >= 0) && (d < Pw) && m_kind_set;
    pr = (d >= 0) && (d < Pw) && !m_kind_set;
    pb = (d >= 0) && (d <= Pw);
    return {ps, pr, pb, m_conf, m_drop};
  endfunction

  task automatic drive_cycle(input logic bs, input logic br, input logic rn);
    @(posedge clk);
    #1;
    if (rst_n) model_edge(btn_set, btn_rst);
    rst_n   = rn;
    btn_set = bs;
    btn_rst = br;
    if (!rn) model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input int n, input logic bs, input logic br);
    for (int i = 0; i < n; i++) drive_cycle(bs, br, 1'b1);
  endtask

  task automatic monitor_loop();
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs {S,R,BUSY,CONFLICT,DROP}", {s, r, busy, conflict, drop}, e);
        check("S and R exclusive", s & r, 0);
      end
      if (!rst_n) begin
        s_len = 0;
        r_len = 0;
      end else begin
        if (s) begin
          if (s_len == 0) begin
            s_rise_cyc = cyc;
            s_count++;
          end
          s_len++;
        end else if (s_len > 0) begin
          check("S pulse width", s_len, Pw);
          s_len = 0;
        end
        if (r) begin
          if (r_len == 0) r_count++;
          r_len++;
        end else if (r_len > 0) begin
          check("R pulse width", r_len, Pw);
          r_len = 0;
        end
        if (conflict) conflict_count++;
        if (drop) drop_count++;
        if (busy) last_busy_cyc = cyc;
      end
    end
  endtask

  initial begin
    int p, q, s0, r0, c0, d0;
    int hold_s, hold_r;
    logic vs, vr;
    model_reset();
    fork
      monitor_loop();
    join_none

    // Reset state.
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
    check("reset outputs", {s, r, busy, conflict, drop}, 5'b0);
    drive_cycle(1'b0, 1'b0, 1'b1);
    hold(5, 1'b0, 1'b0);

    // Clean set press: exact latency, one pulse, busy through guard.
    s0 = s_count; r0 = r_count;
    drive_cycle(1'b1, 1'b0, 1'b1);
    p = cyc;
    hold(40, 1'b1, 1'b0);
    check("set latency", s_rise_cyc, p + 20);
    check("single set pulse", s_count, s0 + 1);
    check("no R on set", r_count, r0);
    check("busy last cycle", last_busy_cyc, p + 24);
    hold(40, 1'b0, 1'b0);

    // Bouncy reset button never settles long enough.
    r0 = r_count;
    hold(10, 1'b0, 1'b1);
    hold(3, 1'b0, 1'b0);
    hold(10, 1'b0, 1'b1);
    hold(40, 1'b0, 1'b0);
    check("bounce gives no R", r_count, r0);

    // Simultaneous presses.
    s0 = s_count; r0 = r_count; c0 = conflict_count;
    hold(40, 1'b1, 1'b1);
    check("conflict pulse", conflict_count, c0 + 1);
    check("no S on conflict", s_count, s0);
    check("no R on conflict", r_count, r0);
    hold(40, 1'b0, 1'b0);

    // Reset request lands in the middle of a set pulse.
    s0 = s_count; r0 = r_count; d0 = drop_count;
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b1);
    hold(40, 1'b1, 1'b1);
    check("drop pulse", drop_count, d0 + 1);
    check("no R after drop", r_count, r0);
    check("S pulse despite drop", s_count, s0 + 1);
    hold(40, 1'b0, 1'b0);

    // Reset in the second S cycle, button still held across release.
    s0 = s_count;
    drive_cycle(1'b1, 1'b0, 1'b1);
    p = cyc;
    repeat (20) drive_cycle(1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0);
    #1;
    check("S cleared by reset", s, 0);
    check("BUSY cleared by reset", busy, 0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1);
    q = cyc;
    hold(40, 1'b1, 1'b0);
    check("set latency after reset", s_rise_cyc, q + 20);
    check("pulses across reset", s_count, s0 + 2);
    hold(40, 1'b0, 1'b0);

    // Random bouncing on both buttons.
    hold_s = 0; hold_r = 0; vs = 1'b0; vr = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (hold_s == 0) begin
        vs = 1'($urandom_range(0, 1));
        hold_s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 60))
                                              : int'($urandom_range(1, 6));
      end
      if (hold_r == 0) begin
        vr = 1'($urandom_range(0, 1));
        hold_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 60))
                                              : int'($urandom_range(1, 6));
      end
      hold_s--;
      hold_r--;
      drive_cycle(vs, vr, 1'b1);
    end
    hold(60, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
